// File: rtl/ws2812_frame_feeder.sv
// Frame feeder for the WS2812 shifter: fetches NUM_LEDS RGB pixels and serves them as G,R,B bytes
// with a one-pixel prefetch. Define WS2812_FEEDER_BRIGHTNESS_EN to add per-frame brightness scaling.
module ws2812_frame_feeder #(
    parameter int NUM_LEDS = 16,
    parameter int ADDR_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
`ifdef WS2812_FEEDER_BRIGHTNESS_EN
    input  logic [7:0]        brightness,
`endif
    output logic              pix_rd,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [23:0]       pix_data,
    output logic              trigger,
    input  logic              data_request,
    output logic [7:0]        data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LEDS - 1);
    localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ARMED = 3'd2,
        ST_SEND  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [23:0]       cur_pix_r, cur_pix_s;
    logic [23:0]       nxt_pix_r, nxt_pix_s;
    logic [1:0]        byte_idx_r, byte_idx_s;
    logic [ADDR_W-1:0] pix_idx_r, pix_idx_s;
    logic [ADDR_W-1:0] addr_hold_r, rd_addr_s;
    logic              rd_pend_r, rd_s, consume_s;
    logic [23:0]       pix_scaled_s;
    logic              out_valid_s;
    logic [7:0]        data_out_r;
    logic              trigger_r, data_valid_r, busy_r, frame_done_r;

    // Wire order is G,R,B; pixel word is {R,G,B}.
    function automatic logic [7:0] byte_sel(input logic [23:0] pix, input logic [1:0] idx);
        case (idx)
            2'd0:    byte_sel = pix[15:8];
            2'd1:    byte_sel = pix[23:16];
            2'd2:    byte_sel = pix[7:0];
            default: byte_sel = 8'h00;
        endcase
    endfunction

`ifdef WS2812_FEEDER_BRIGHTNESS_EN
    logic [7:0] bright_r, bright_s;

    function automatic logic [7:0] scale_byte(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'h00, c} * ({8'h00, b} + 16'd1);
        return 8'(prod >> 8);
    endfunction

    // Brightness is latched only when a frame is accepted.
    always_comb begin
        bright_s = bright_r;
        if ((state_r == ST_IDLE) && frame_start) begin
            bright_s = brightness;
        end else begin
            bright_s = bright_r;
        end
    end

    // Brightness register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bright_r <= 8'h00;
        end else begin
            bright_r <= bright_s;
        end
    end

    // Scaling happens at capture so data_out gains no latency.
    always_comb begin
        pix_scaled_s = {scale_byte(pix_data[23:16], bright_r),
                        scale_byte(pix_data[15:8],  bright_r),
                        scale_byte(pix_data[7:0],   bright_r)};
    end
`else
    // Without brightness scaling the pixel passes through untouched.
    always_comb begin
        pix_scaled_s = pix_data;
    end
`endif

    // Next-state, pixel buffers, memory read issue.
    always_comb begin
        state_s    = state_r;
        cur_pix_s  = cur_pix_r;
        nxt_pix_s  = nxt_pix_r;
        byte_idx_s = byte_idx_r;
        pix_idx_s  = pix_idx_r;
        rd_s       = 1'b0;
        rd_addr_s  = addr_hold_r;
        consume_s  = data_request && data_valid_r;

        // Read data lands one cycle after the strobe: the first read fills cur_pix, the rest nxt_pix.
        if (rd_pend_r && (state_r == ST_LOAD)) begin
            cur_pix_s = pix_scaled_s;
        end else if (rd_pend_r) begin
            nxt_pix_s = pix_scaled_s;
        end else begin
            nxt_pix_s = nxt_pix_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (frame_start) begin
                    rd_s      = 1'b1;
                    rd_addr_s = '0;
                    pix_idx_s = '0;
                    state_s   = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                byte_idx_s = 2'd0;
                state_s    = ST_ARMED;
                if (NUM_LEDS > 1) begin
                    rd_s      = 1'b1;
                    rd_addr_s = ONE_IDX;
                end else begin
                    rd_s = 1'b0;
                end
            end
            ST_ARMED: begin
                if (consume_s) begin
                    byte_idx_s = 2'd1;
                    state_s    = ST_SEND;
                end else begin
                    state_s = ST_ARMED;
                end
            end
            ST_SEND: begin
                if (consume_s) begin
                    case (byte_idx_r)
                        2'd0: begin
                            // Pixel 1 was fetched during LOAD; later pixels prefetch on their G byte.
                            byte_idx_s = 2'd1;
                            if (pix_idx_r != LAST_IDX) begin
                                rd_s      = 1'b1;
                                rd_addr_s = pix_idx_r + ONE_IDX;
                            end else begin
                                rd_s = 1'b0;
                            end
                        end
                        2'd1: begin
                            byte_idx_s = 2'd2;
                        end
                        2'd2: begin
                            if (pix_idx_r == LAST_IDX) begin
                                state_s = ST_DONE;
                            end else begin
                                cur_pix_s  = nxt_pix_r;
                                byte_idx_s = 2'd0;
                                pix_idx_s  = pix_idx_r + ONE_IDX;
                            end
                        end
                        default: begin
                            byte_idx_s = 2'd0;
                        end
                    endcase
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        out_valid_s = (state_s == ST_ARMED) || (state_s == ST_SEND);
    end

    // State, buffers and registered shifter-facing outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cur_pix_r    <= 24'h000000;
            nxt_pix_r    <= 24'h000000;
            byte_idx_r   <= 2'd0;
            pix_idx_r    <= '0;
            addr_hold_r  <= '0;
            rd_pend_r    <= 1'b0;
            data_out_r   <= 8'h00;
            trigger_r    <= 1'b0;
            data_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            cur_pix_r    <= cur_pix_s;
            nxt_pix_r    <= nxt_pix_s;
            byte_idx_r   <= byte_idx_s;
            pix_idx_r    <= pix_idx_s;
            addr_hold_r  <= rd_addr_s;
            rd_pend_r    <= rd_s;
            data_out_r   <= out_valid_s ? byte_sel(cur_pix_s, byte_idx_s) : 8'h00;
            trigger_r    <= (state_s == ST_ARMED);
            data_valid_r <= out_valid_s;
            busy_r       <= (state_s != ST_IDLE);
            frame_done_r <= (state_s == ST_DONE);
        end
    end

    assign pix_rd     = rd_s;
    assign pix_addr   = rd_addr_s;
    assign trigger    = trigger_r;
    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_ws2812_frame_feeder.sv
// Bench for ws2812_frame_feeder: a 4-pixel and a 1-pixel instance driven by a shifter model,
// with expected bytes queued at frame start and compared on each request.
module tb_ws2812_frame_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, fs1, fs4, data_request, sel;
`ifdef WS2812_FEEDER_BRIGHTNESS_EN
    logic [7:0]  brightness = 8'd255;
`endif

    logic        d4_rd, d4_trig, d4_dv, d4_busy, d4_fd;
    logic [1:0]  d4_addr;
    logic [23:0] pd4;
    logic [7:0]  d4_dout;
    logic        d1_rd, d1_trig, d1_dv, d1_busy, d1_fd;
    logic [0:0]  d1_addr;
    logic [23:0] pd1;
    logic [7:0]  d1_dout;

    logic [23:0] mem4 [4] = '{24'hA1B2C3, 24'h102030, 24'hFFEE01, 24'h00FF80};
    logic [23:0] mem1 = 24'h123456;

    logic [7:0]  exp_q [$];
    logic [1:0]  rd_q [$];
    int passed = 0, fails = 0, total = 0;
    int fd4_cnt = 0, fd1_cnt = 0, drop_cnt = 0;
    logic drop_en = 1'b0;

    ws2812_frame_feeder #(.NUM_LEDS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .frame_start(fs4),
`ifdef WS2812_FEEDER_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .pix_rd(d4_rd), .pix_addr(d4_addr), .pix_data(pd4), .trigger(d4_trig),
        .data_request(data_request), .data_out(d4_dout), .data_valid(d4_dv),
        .busy(d4_busy), .frame_done(d4_fd)
    );

    ws2812_frame_feeder #(.NUM_LEDS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .frame_start(fs1),
`ifdef WS2812_FEEDER_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .pix_rd(d1_rd), .pix_addr(d1_addr), .pix_data(pd1), .trigger(d1_trig),
        .data_request(data_request), .data_out(d1_dout), .data_valid(d1_dv),
        .busy(d1_busy), .frame_done(d1_fd)
    );

    // Synchronous pixel memories plus read/frame_done logging.
    always @(posedge clk) begin
        if (d4_rd) begin
            pd4 <= mem4[d4_addr];
            rd_q.push_back(d4_addr);
        end
        if (d1_rd) pd1 <= mem1;
        if (d4_fd) fd4_cnt <= fd4_cnt + 1;
        if (d1_fd) fd1_cnt <= fd1_cnt + 1;
        if (drop_en && (exp_q.size() > 0) && !d4_dv) drop_cnt <= drop_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Shifter model: wait gap cycles, raise data_request for one clock, compare against the scoreboard.
    task automatic req(input int gap);
        logic [7:0] e;
        repeat (gap) @(negedge clk);
        data_request = 1'b1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("valid", 32'(sel ? d1_dv : d4_dv), 32'd1);
            chk("byte", 32'(sel ? d1_dout : d4_dout), 32'(e));
        end else begin
            chk("valid_end", 32'(sel ? d1_dv : d4_dv), 32'd0);
        end
        @(negedge clk);
        data_request = 1'b0;
    endtask

    task automatic push4();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mem4[i][15:8]);
            exp_q.push_back(mem4[i][23:16]);
            exp_q.push_back(mem4[i][7:0]);
        end
    endtask

    task automatic start4();
        rd_q.delete();
        push4();
        @(negedge clk);
        fs4 = 1'b1;
        #1 chk("start_rd_addr0", 32'({d4_rd, d4_addr}), 32'h4);
        @(negedge clk);
        fs4 = 1'b0;
    endtask

    task automatic check_reads();
        chk("rd_count", 32'(rd_q.size()), 32'd4);
        for (int i = 0; i < rd_q.size() && i < 4; i++) chk("rd_addr", 32'(rd_q[i]), 32'(i));
    endtask

    initial begin
        int hold, fd_base;
        rst_n = 1'b0; fs1 = 1'b0; fs4 = 1'b0; data_request = 1'b0; sel = 1'b0;
        #12;
        chk("rst_ctrl", 32'({d4_rd, d4_trig, d4_dv, d4_busy, d4_fd}), 32'd0);
        chk("rst_dout", 32'(d4_dout), 32'd0);
        chk("rst_addr", 32'(d4_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-pixel frame, slow shifter
        sel = 1'b1;
        exp_q.push_back(8'h34); exp_q.push_back(8'h12); exp_q.push_back(8'h56);
        @(negedge clk);
        fs1 = 1'b1;
        #1 chk("d1_start_rd", 32'({d1_rd, d1_addr}), 32'h2);
        @(negedge clk);
        fs1 = 1'b0;
        repeat (98) @(negedge clk);
        chk("d1_trig_hold", 32'({d1_trig, d1_dv}), 32'h3);
        req(1);
        chk("d1_trig_drop", 32'(d1_trig), 32'd0);
        repeat (3) req(99);
        repeat (3) @(negedge clk);
        chk("d1_frame_done", 32'(fd1_cnt), 32'd1);
        chk("d1_idle", 32'(d1_busy), 32'd0);

        // Four pixels, requests spaced 8 cycles
        sel = 1'b0;
        fd_base = fd4_cnt;
        start4();
        @(negedge clk);
        drop_en = 1'b1;
        repeat (12) req(8);
        drop_en = 1'b0;
        req(8);
        chk("no_valid_gap", 32'(drop_cnt), 32'd0);
        check_reads();
        chk("d4_frame_done", 32'(fd4_cnt - fd_base), 32'd1);
        chk("d4_idle", 32'(d4_busy), 32'd0);

        // Late first request (tail guard) and a frame_start mid-frame
        fd_base = fd4_cnt;
        start4();
        hold = 0;
        repeat (500) begin
            @(negedge clk);
            if (d4_trig && d4_dv) hold++;
        end
        chk("trig_hold_500", 32'(hold), 32'd500);
        req(0);
        repeat (4) req(8);
        @(negedge clk);
        fs4 = 1'b1;
        #1 chk("fs_ignored_rd", 32'(d4_rd), 32'd0);
        @(negedge clk);
        fs4 = 1'b0;
        repeat (7) req(8);
        req(8);
        check_reads();
        chk("single_done", 32'(fd4_cnt - fd_base), 32'd1);

        // Reset during pixel 2, then a fresh frame
        fd_base = fd4_cnt;
        start4();
        repeat (7) req(8);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ctrl", 32'({d4_rd, d4_trig, d4_dv, d4_busy, d4_fd}), 32'd0);
        chk("arst_dout", 32'(d4_dout), 32'd0);
        chk("arst_addr", 32'(d4_addr), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        start4();
        repeat (12) req(8);
        req(8);
        check_reads();
        chk("done_after_rst", 32'(fd4_cnt - fd_base), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
